// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: funct3 codes, FSM encoding and byte-enable patterns shared by the LSU
package lsu_mem_ctrl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT} state_t;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == 2'b00 ? BE_B << off : f3[1:0] == 2'b01 ? BE_H << {off[1], 1'b0} : BE_W;
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_load_data_aligner.sv
// load_data_aligner: picks the byte/halfword at the address offset and extends it to 32 bits
module load_data_aligner
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    result = func3 == F3_B  ? {{24{b[7]}}, b} :
             func3 == F3_BU ? {24'b0, b} :
             func3 == F3_H  ? {{16{h[15]}}, h} :
             func3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: rv32i load/store sequencer; TIMEOUT counts WAIT cycles, a rsp in the last one still wins
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_func3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [31:0]       core_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata
);
  state_t            state, state_n;
  logic              we_q, err_q, legal, aligned;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, ld_data;
  logic [CNT_W-1:0]  cnt;
  assign legal   = core_we ? core_func3 inside {F3_B, F3_H, F3_W}
                           : core_func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign aligned = core_func3[1:0] == 2'b01 ? !core_addr[0] :
                   core_func3[1:0] == 2'b10 ? core_addr[1:0] == 2'b00 : 1'b1;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                     f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  load_data_aligner u_align (.rdata(mem_rdata), .off(addr_q[1:0]), .func3(f3_q), .result(ld_data));
  always_comb begin
    state_n       = state;
    core_busy     = state != S_IDLE;
    core_done     = state == S_DONE;
    core_err      = core_done & err_q;
    mem_req_valid = state == S_REQ;
    mem_we        = mem_req_valid & we_q;
    mem_be        = mem_req_valid ? lane_be(f3_q, addr_q[1:0]) : 4'b0000;
    case (state)
      S_IDLE:  if (core_req) state_n = legal && aligned ? S_REQ : S_FAULT;
      S_REQ:   if (mem_req_ready) state_n = S_WAIT;
      S_WAIT:  if (mem_rsp_valid || cnt == CNT_W'(TIMEOUT - 1)) state_n = S_DONE;
      S_FAULT: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      core_rdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == S_WAIT ? cnt + 1'b1 : '0;
      if (state == S_IDLE && core_req) begin
        we_q    <= core_we;
        f3_q    <= core_func3;
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
      end
      if (state == S_FAULT) err_q <= 1'b1;
      if (state == S_WAIT) begin
        err_q <= !mem_rsp_valid;
        if (mem_rsp_valid && !we_q) core_rdata <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized transactions checked each cycle against a transaction-level timeline model
module tb_lsu_mem_ctrl;
  localparam int TO = 3;
  logic        clk = 1'b0, rst;
  logic        core_req, core_we, core_busy, core_done, core_err;
  logic [2:0]  core_func3;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  always #5 clk = ~clk;
  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we), .core_func3(core_func3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_busy(core_busy), .core_done(core_done),
    .core_err(core_err), .core_rdata(core_rdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata));

  int checks = 0, errors = 0;
  logic chk_en = 1'b0;
  logic e_busy, e_done, e_err, e_valid, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_rdata;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int sz_of(input logic [2:0] f);
    return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
  endfunction
  function automatic logic legal_m(input logic we, input logic [2:0] f, input logic [31:0] a);
    logic f_ok;
    f_ok = we ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    return f_ok && (a % sz_of(f) == 0);
  endfunction
  function automatic logic [3:0] be_m(input logic [2:0] f, input logic [31:0] a);
    return 4'(((1 << sz_of(f)) - 1) << (a % 4));
  endfunction
  function automatic logic [31:0] wd_m(input logic [2:0] f, input logic [31:0] w);
    return sz_of(f) == 1 ? (w & 32'hFF) * 32'h01010101 :
           sz_of(f) == 2 ? (w & 32'hFFFF) * 32'h00010001 : w;
  endfunction
  function automatic logic [31:0] ld_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    if (sz_of(f) == 4) return rd;
    mask = sz_of(f) == 1 ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * (a % 4))) & mask;
    if (f < 3'd4 && (v & ~(mask >> 1)) != 0) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("core_busy", core_busy, e_busy);
    chk("core_done", core_done, e_done);
    chk("mem_req_valid", mem_req_valid, e_valid);
    chk("core_rdata", core_rdata, e_rdata);
    if (e_done) chk("core_err", core_err, e_err);
    if (e_valid) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_be", mem_be, e_be);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic junk();
    core_req = 1'($urandom); core_we = 1'($urandom); core_func3 = 3'($urandom);
    core_addr = $urandom; core_wdata = $urandom; mem_rdata = $urandom;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      core_req = 1'b0; mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
      e_busy = 1'b0; e_done = 1'b0; e_valid = 1'b0;
      cyc();
    end
  endtask

  // rd: ready stall cycles; rspd: WAIT cycles before rsp (>= TO means never)
  task automatic txn(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] w,
                     input int rd, input int rspd, input logic [31:0] rdw);
    core_req = 1'b1; core_we = we; core_func3 = f; core_addr = a; core_wdata = w;
    mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
    e_busy = 1'b0; e_done = 1'b0; e_valid = 1'b0;
    cyc();
    e_busy = 1'b1;
    if (!legal_m(we, f, a)) begin
      junk(); mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
      cyc();
      e_err = 1'b1;
    end else begin
      e_valid = 1'b1; e_addr = a & ~32'h3; e_we = we; e_be = be_m(f, a); e_wdata = wd_m(f, w);
      for (int i = 0; i <= rd; i++) begin
        junk(); mem_req_ready = (i == rd); mem_rsp_valid = 1'($urandom);
        cyc();
      end
      e_valid = 1'b0;
      for (int i = 0; i < TO; i++) begin
        junk(); mem_req_ready = 1'($urandom); mem_rsp_valid = (i == rspd);
        if (i == rspd) mem_rdata = rdw;
        cyc();
        if (i == rspd) break;
      end
      e_err = rspd >= TO;
      if (!e_err && !we) e_rdata = ld_m(f, a, rdw);
    end
    junk(); mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
    e_done = 1'b1;
    cyc();
    e_done = 1'b0;
    core_req = 1'b0;
  endtask

  task automatic rst_in_wait();
    core_req = 1'b1; core_we = 1'b0; core_func3 = 3'b010; core_addr = 32'h40; core_wdata = $urandom;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_valid = 1'b0;
    cyc();
    junk(); mem_req_ready = 1'b1;
    e_busy = 1'b1; e_valid = 1'b1; e_addr = 32'h40; e_we = 1'b0; e_be = 4'hF;
    cyc();
    junk(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; rst = 1'b1; e_valid = 1'b0;
    cyc();
    rst = 1'b0; core_req = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    e_busy = 1'b0; e_rdata = 32'h0;
    cyc();
    mem_rsp_valid = 1'b0;
    idle(3);
  endtask

  initial begin
    logic [2:0] f3s [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_func3 = '0; core_addr = '0; core_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_valid = 1'b0; e_we = 1'b0;
    e_be = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    chk("pin_be_sb", be_m(3'd0, 32'h103), 32'h8);
    chk("pin_wd_sb", wd_m(3'd0, 32'hAB), 32'hABABABAB);
    chk("pin_be_lh", be_m(3'd1, 32'h202), 32'hC);
    chk("pin_ld_lh", ld_m(3'd1, 32'h202, 32'h80011234), 32'hFFFF8001);
    chk("pin_ld_lhu", ld_m(3'd5, 32'h202, 32'h80011234), 32'h00008001);
    chk("pin_ld_lb", ld_m(3'd0, 32'h1, 32'h000080FF), 32'hFFFFFF80);
    chk("pin_illegal_sw", legal_m(1'b1, 3'd2, 32'h1), 32'h0);
    txn(1'b1, 3'd0, 32'h103, 32'hAB, 0, 0, 32'h0);
    idle(1);
    txn(1'b0, 3'd1, 32'h202, 32'h0, 0, 0, 32'h80011234);
    chk("lh_rdata_held", core_rdata, 32'hFFFF8001);
    txn(1'b0, 3'd5, 32'h202, 32'h0, 0, 0, 32'h80011234);
    chk("lhu_rdata_held", core_rdata, 32'h00008001);
    txn(1'b1, 3'd2, 32'h1, 32'h12345678, 0, 0, 32'h0);
    chk("fault_rdata_kept", core_rdata, 32'h00008001);
    txn(1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 4, 0, 32'h0);
    txn(1'b0, 3'd2, 32'h400, 32'h0, 1, TO, 32'h11111111);
    txn(1'b0, 3'd2, 32'h404, 32'h0, 0, TO - 1, 32'h22222222);
    rst_in_wait();
    for (int n = 0; n < 300; n++) begin
      txn(1'($urandom), f3s[$urandom_range(0, 9)], $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, TO), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the rv32i execute stage and a handshaked data-memory port.
- Accepts one load/store request at a time from the core.
- Applies RISC-V alignment checks, builds the lane byte-enable and lane-replicated write data, and runs the memory request/response handshake with a timeout.
- For loads, extracts and sign/zero-extends the result.
- Stalls the core via core_busy until completion.

Parameters:
ADDR_W, 32, byte-address width of core_addr/mem_addr
TIMEOUT, 255, max cycles waiting in WAIT for mem_rsp_valid before error (1..2^CNT_W-1)
CNT_W, 8, width of timeout counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
core_req  in  1  request strobe; sampled only in IDLE
core_we  in  1  1=store, 0=load
core_func3  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
core_addr  in  ADDR_W  byte address
core_wdata  in  32  store data (rs2), right-justified
core_busy  out  1  high in every state except IDLE
core_done  out  1  one-cycle completion pulse
core_err  out  1  valid with core_done; 1 = misaligned/illegal/timeout
core_rdata  out  32  extended load data; valid with core_done, held until next done
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_rsp_valid  in  1  read data / write ack valid
mem_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE. core_busy, core_done, core_err, mem_req_valid, mem_we = 0. mem_be=0. core_rdata=0. Timeout counter=0.
- FSM states: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE:
  - On core_req, latch we/func3/addr/wdata.
  - Legality: store func3 must be 000/001/010; load func3 must be 000/001/010/100/101.
  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal or misaligned request -> FAULT; otherwise -> REQ.
- REQ:
  - mem_req_valid=1; mem_addr/mem_we/mem_be/mem_wdata held stable until mem_req_ready.
  - Handshake cycle (valid&ready) -> WAIT; counter cleared.
- WAIT:
  - mem_req_valid=0; counter increments each cycle.
  - mem_rsp_valid -> capture result, go DONE, err=0.
  - counter==TIMEOUT without rsp -> DONE, err=1, core_rdata unchanged.
  - If rsp arrives in the same cycle the counter hits TIMEOUT, rsp wins.
- FAULT: -> DONE, err=1; no memory transaction issued.
- DONE: core_done=1 for exactly one cycle, core_err per cause; -> IDLE.
- core_req is ignored while not IDLE. A new request may be accepted the cycle after DONE.
- mem_rsp_valid outside WAIT is ignored.
- Byte enables:
  - sb: one-hot lane at addr[1:0] (00->0001, 01->0010, 10->0100, 11->1000).
  - sh: addr[1]=0 -> 0011, addr[1]=1 -> 1100.
  - sw: 1111.
  - Loads drive mem_be with the same pattern.
- Write data: sb -> {4{wdata[7:0]}}; sh -> {2{wdata[15:0]}}; sw -> wdata.
- Load extraction: select byte/halfword at addr offset. func3 000/001 sign-extend; 100/101 zero-extend; 010 pass-through. Stores leave core_rdata unchanged.
- Latency: request sampled in cycle T; mem_req_valid in T+1; with ready at T+1 and rsp at T+2, core_done at T+3. Each ready/rsp wait cycle adds 1. Fault completes at T+2.
- Reset mid-operation: immediate return to IDLE and outputs to reset values. Any in-flight transaction is abandoned; the memory shares rst.

Decomposition:
- Shared package holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding (3-bit).
  - Byte-enable constant patterns.
- One combinational sub-module, load_data_aligner (rdata word, offset, func3 -> extended 32-bit result).
- Byte-enable and write replication stay inline.

Test Plan:
- Store byte: func3=000, addr=0x103, wdata=0xAB, ready=1 immediately, rsp 1 cycle later -> mem_be=1000, mem_addr=0x100, mem_wdata=0xABABABAB, mem_we=1; core_done at T+3, err=0.
- Load halfword signed: func3=001, addr=0x202, mem_rdata=0x8001_1234 -> mem_be=1100, core_rdata=0xFFFF8001. Same with func3=101 -> 0x00008001.
- Misaligned word store: func3=010, addr=0x1 -> no mem_req_valid ever; core_done+core_err at T+2.
- Backpressure: ready held low 4 cycles -> mem_req_valid and all mem_* fields stable throughout; core_busy=1; done 4 cycles later than baseline.
- Timeout: TIMEOUT=3, rsp never asserted -> core_done with err=1 after 3 WAIT cycles. Next core_req accepted the cycle after done.
- Reset in WAIT: assert rst for one cycle -> core_busy=0, mem_req_valid=0; a late mem_rsp_valid produces no core_done.
